// File: rtl/param_paper_processor.sv
// param_paper_processor
//
// Parametrised paper-computer core. A small program store is loaded while the
// core is idle. A start pulse then runs the program from address 0 through a
// two-phase FETCH/EXEC loop until a HALT instruction returns it to IDLE.
// Each instruction word is {op[2:0], ridx[RI_W-1:0], tgt[PC_W-1:0]}, MSB first.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset (program store is kept)
//   clk_en       execution enable; the state machine only advances when high
//   start        begin execution at address 0 (taken only in IDLE)
//   prog_we      program store write strobe (taken only in IDLE, ignores clk_en)
//   prog_addr    program store write address
//   prog_wdata   program store write data
//   reg_sel      debug register select
//   reg_rdata    combinational read of register reg_sel (0 if out of range)
//   programCount current program counter
//   stateCount   state: 00 IDLE, 01 FETCH, 10 EXEC
//   instruction  latched instruction register
//   running      high in FETCH and EXEC
//   halted       sticky HALT flag, cleared by start or reset
//   retired      completed-instruction count, saturating at 16'hFFFF
module param_paper_processor #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int PC_W     = 4,
  localparam int RI_W    = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1,
  localparam int INSTR_W = 3 + RI_W + PC_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               start,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_wdata,
  input  logic [RI_W-1:0]    reg_sel,
  output logic [DATA_W-1:0]  reg_rdata,
  output logic [PC_W-1:0]    programCount,
  output logic [1:0]         stateCount,
  output logic [INSTR_W-1:0] instruction,
  output logic               running,
  output logic               halted,
  output logic [15:0]        retired
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_INC  = 3'b001,
    OP_DEC  = 3'b010,
    OP_JZ   = 3'b011,
    OP_JMP  = 3'b100,
    OP_CLR  = 3'b101,
    OP_JNZ  = 3'b110,
    OP_HALT = 3'b111
  } opcode_t;

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [DATA_W-1:0]    regFile_q [NUM_REGS];
  logic [DATA_W-1:0]    regFile_d [NUM_REGS];
  logic [15:0]          retired_q, retired_d;
  logic                 halted_q, halted_d;
  logic [INSTR_W-1:0]   progMem_q [2**PC_W];

  opcode_t              op;
  logic [RI_W-1:0]      ridx;
  logic [PC_W-1:0]      tgt;
  logic                 ridxOk;
  logic [DATA_W-1:0]    rval;
  logic [PC_W-1:0]      pcNext;

  // Field decode of the latched instruction. Registers past NUM_REGS read as
  // zero, which is what makes JZ on them always taken and JNZ never taken.
  always_comb begin
    op     = opcode_t'(instr_q[INSTR_W-1 -: 3]);
    ridx   = instr_q[PC_W +: RI_W];
    tgt    = instr_q[PC_W-1:0];
    ridxOk = int'(ridx) < NUM_REGS;
    rval   = '0;
    if (ridxOk) rval = regFile_q[ridx];
    pcNext = pc_q + PC_W'(1);
  end

  // Program store: no reset so a loaded program survives reset pulses, and
  // writes only depend on being idle, not on clk_en.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == IDLE)) progMem_q[prog_addr] <= prog_wdata;
  end

  // Next-state and datapath update; everything holds unless clk_en is high.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    regFile_d = regFile_q;
    retired_d = retired_q;
    halted_d  = halted_q;
    if (clk_en) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d  = FETCH;
            pc_d     = '0;
            halted_d = 1'b0;
          end
        end
        FETCH: begin
          instr_d = progMem_q[pc_q];
          state_d = EXEC;
        end
        EXEC: begin
          retired_d = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;
          state_d   = FETCH;
          pc_d      = pcNext;
          case (op)
            OP_INC: if (ridxOk) regFile_d[ridx] = rval + DATA_W'(1);
            OP_DEC: if (ridxOk && (rval != '0)) regFile_d[ridx] = rval - DATA_W'(1);
            OP_CLR: if (ridxOk) regFile_d[ridx] = '0;
            OP_JZ:  if (rval == '0) pc_d = tgt;
            OP_JNZ: if (rval != '0) pc_d = tgt;
            OP_JMP: pc_d = tgt;
            OP_HALT: begin
              state_d  = IDLE;
              pc_d     = pc_q;
              halted_d = 1'b1;
            end
            default: ;
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register; reset clears everything except the program store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regFile_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
      regFile_q <= regFile_d;
    end
  end

  // Debug read port: out-of-range selects return zero.
  always_comb begin
    reg_rdata = '0;
    if (int'(reg_sel) < NUM_REGS) reg_rdata = regFile_q[reg_sel];
  end

  assign programCount = pc_q;
  assign stateCount   = state_q;
  assign instruction  = instr_q;
  assign running      = (state_q != IDLE);
  assign halted       = halted_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_param_paper_processor.sv
// Testbench for param_paper_processor. Instance dutA uses the defaults
// (8-bit data, 4 registers, 16-word program) and is tracked every cycle by an
// instruction-level model. Instance dutB uses 3 registers so that register
// index 3 is out of range.
module tb_param_paper_processor;

  logic       clk = 1'b0;
  logic       reset, clk_en, start, prog_we;
  logic [3:0] prog_addr;
  logic [8:0] prog_wdata;
  logic [1:0] reg_sel;
  logic [7:0] reg_rdata;
  logic [3:0] programCount;
  logic [1:0] stateCount;
  logic [8:0] instruction;
  logic       running, halted;
  logic [15:0] retired;

  logic       bReset, bClkEn, bStart, bProgWe;
  logic [3:0] bProgAddr;
  logic [8:0] bProgWdata;
  logic [1:0] bRegSel;
  logic [7:0] bRegRdata;
  logic [3:0] bProgramCount;
  logic [1:0] bStateCount;
  logic [8:0] bInstruction;
  logic       bRunning, bHalted;
  logic [15:0] bRetired;

  int nChecks = 0;
  int nPass   = 0;

  // Behavioural model of dutA
  int mMode;            // 0 idle, 1 fetch, 2 exec
  int mPc, mIr, mRet, mHalt;
  int mRegs [4];
  int mMem  [16];

  param_paper_processor #(.DATA_W(8), .NUM_REGS(4), .PC_W(4)) dutA (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .reg_sel(reg_sel), .reg_rdata(reg_rdata), .programCount(programCount),
    .stateCount(stateCount), .instruction(instruction), .running(running),
    .halted(halted), .retired(retired)
  );

  param_paper_processor #(.DATA_W(8), .NUM_REGS(3), .PC_W(4)) dutB (
    .clk(clk), .reset(bReset), .clk_en(bClkEn), .start(bStart),
    .prog_we(bProgWe), .prog_addr(bProgAddr), .prog_wdata(bProgWdata),
    .reg_sel(bRegSel), .reg_rdata(bRegRdata), .programCount(bProgramCount),
    .stateCount(bStateCount), .instruction(bInstruction), .running(bRunning),
    .halted(bHalted), .retired(bRetired)
  );

  always #10 clk = ~clk;

  function automatic logic [8:0] enc(int op, int r, int t);
    return {3'(op), 2'(r), 4'(t)};
  endfunction

  task automatic check(string name, longint act, longint exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic modelReset();
    mMode = 0; mPc = 0; mIr = 0; mRet = 0; mHalt = 0;
    for (int i = 0; i < 4; i++) mRegs[i] = 0;
  endtask

  // One clock edge of the programmer-visible machine
  task automatic modelEdge(bit en, bit st, bit we, int addr, int data);
    int op, r, t, v, nxt;
    if (mMode == 0 && we) mMem[addr] = data;
    if (!en) return;
    if (mMode == 0) begin
      if (st) begin mMode = 1; mPc = 0; mHalt = 0; end
    end else if (mMode == 1) begin
      mIr = mMem[mPc];
      mMode = 2;
    end else begin
      op = (mIr >> 6) & 7; r = (mIr >> 4) & 3; t = mIr & 15;
      v = mRegs[r];
      nxt = (mPc + 1) % 16;
      mMode = 1;
      case (op)
        1: mRegs[r] = (v + 1) % 256;
        2: mRegs[r] = (v > 0) ? v - 1 : 0;
        3: if (v == 0) nxt = t;
        4: nxt = t;
        5: mRegs[r] = 0;
        6: if (v != 0) nxt = t;
        7: begin mHalt = 1; nxt = mPc; mMode = 0; end
        default: ;
      endcase
      mPc = nxt;
      if (mRet < 65535) mRet++;
    end
  endtask

  task automatic checkOutput();
    check("state", stateCount, mMode);
    check("pc", programCount, mPc);
    check("instruction", instruction, mIr);
    check("running", running, (mMode != 0));
    check("halted", halted, mHalt);
    check("retired", retired, mRet);
    for (int r = 0; r < 4; r++) begin
      reg_sel = 2'(r);
      #1;
      check($sformatf("r%0d", r), reg_rdata, mRegs[r]);
    end
  endtask

  task automatic applyStimulus(bit en, bit st, bit we, int addr, int data);
    clk_en = en; start = st; prog_we = we;
    prog_addr = 4'(addr); prog_wdata = 9'(data);
    @(posedge clk);
    #1;
    modelEdge(en, st, we, addr, data);
    checkOutput();
  endtask

  task automatic doReset();
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0; clk_en = 1'b0;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput();
    reset = 1'b0;
  endtask

  task automatic loadWord(int addr, logic [8:0] data);
    applyStimulus(1'b0, 1'b0, 1'b1, addr, int'(data));
  endtask

  task automatic readReg(int r, output int v);
    reg_sel = 2'(r);
    #1;
    v = int'(reg_rdata);
  endtask

  // Starts the program and clocks until halted; toggle alternates clk_en and
  // tries to overwrite address 5 while running.
  task automatic runProgram(bit toggle, output int cycles);
    bit en, we;
    cycles = 0;
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0);
    while (!halted) begin
      cycles++;
      if (cycles > 3000) begin
        check("halt_timeout", 0, 1);
        return;
      end
      en = toggle ? (cycles % 2 == 0) : 1'b1;
      we = toggle && (cycles == 4);
      applyStimulus(en, 1'b0, we, 5, int'(enc(0, 0, 0)));
    end
  endtask

  task automatic bStep(bit en, bit st, bit we, int addr, logic [8:0] data);
    bClkEn = en; bStart = st; bProgWe = we;
    bProgAddr = 4'(addr); bProgWdata = data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c, cLoop, cTog, v, bc;
    reset = 1'b1; clk_en = 1'b0; start = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_wdata = '0; reg_sel = '0;
    bReset = 1'b1; bClkEn = 1'b0; bStart = 1'b0; bProgWe = 1'b0;
    bProgAddr = '0; bProgWdata = '0; bRegSel = '0;
    for (int i = 0; i < 16; i++) mMem[i] = 0;
    modelReset();

    // Reset state
    doReset();
    check("reset_state_lit", stateCount, 0);
    check("reset_retired_lit", retired, 0);

    // {INC r1, INC r1, HALT}
    loadWord(0, enc(1, 1, 0));
    loadWord(1, enc(1, 1, 0));
    loadWord(2, enc(7, 0, 0));
    runProgram(1'b0, c);
    check("p1_halted_lit", halted, 1);
    check("p1_pc_lit", programCount, 2);
    check("p1_retired_lit", retired, 3);
    readReg(1, v);
    check("p1_r1_lit", v, 2);

    // Countdown loop
    doReset();
    for (int i = 0; i < 3; i++) loadWord(i, enc(1, 0, 0));
    loadWord(3, enc(2, 0, 0));
    loadWord(4, enc(6, 0, 3));
    loadWord(5, enc(7, 0, 0));
    runProgram(1'b0, cLoop);
    readReg(0, v);
    check("loop_r0_lit", v, 0);
    check("loop_retired_lit", retired, 10);
    check("loop_pc_lit", programCount, 5);

    // Same loop with clk_en toggling and a write attempt while running
    doReset();
    runProgram(1'b1, cTog);
    readReg(0, v);
    check("toggle_r0_lit", v, 0);
    check("toggle_retired_lit", retired, 10);
    check("toggle_cycles", cTog, 2 * cLoop);
    doReset();
    runProgram(1'b0, c);
    check("rerun_pc_lit", programCount, 5);
    check("rerun_retired_lit", retired, 10);

    // INC wrap 255 -> 0 on r2
    doReset();
    loadWord(0, enc(1, 2, 0));
    loadWord(1, enc(6, 2, 0));
    loadWord(2, enc(7, 0, 0));
    runProgram(1'b0, c);
    readReg(2, v);
    check("wrap_r2_lit", v, 0);
    check("wrap_retired_lit", retired, 513);

    // DEC saturates at 0
    doReset();
    loadWord(0, enc(2, 3, 0));
    loadWord(1, enc(7, 0, 0));
    runProgram(1'b0, c);
    readReg(3, v);
    check("dec_r3_lit", v, 0);

    // JMP 15 then PC wraps to 0
    doReset();
    loadWord(0, enc(6, 1, 3));
    loadWord(1, enc(1, 1, 0));
    loadWord(2, enc(4, 0, 15));
    loadWord(3, enc(7, 0, 0));
    loadWord(15, enc(0, 0, 0));
    runProgram(1'b0, c);
    check("jmp_retired_lit", retired, 6);
    check("jmp_pc_lit", programCount, 3);

    // Reset during EXEC of the sixth INC r1
    doReset();
    for (int i = 0; i < 6; i++) loadWord(i, enc(1, 1, 0));
    loadWord(6, enc(7, 0, 0));
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 11; i++) applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    check("mid_state_lit", stateCount, 2);
    readReg(1, v);
    check("mid_r1_lit", v, 5);
    reset = 1'b1;
    #1;
    check("midrst_state_lit", stateCount, 0);
    check("midrst_pc_lit", programCount, 0);
    check("midrst_instr_lit", instruction, 0);
    check("midrst_running_lit", running, 0);
    check("midrst_halted_lit", halted, 0);
    check("midrst_retired_lit", retired, 0);
    readReg(1, v);
    check("midrst_r1_lit", v, 0);
    modelReset();
    reset = 1'b0;
    runProgram(1'b0, c);
    readReg(1, v);
    check("restart_r1_lit", v, 6);
    check("restart_retired_lit", retired, 7);

    // Out-of-range register index on the 3-register instance
    @(negedge clk);
    bReset = 1'b0;
    bStep(1'b1, 1'b0, 1'b1, 0, enc(1, 3, 0));
    bStep(1'b1, 1'b0, 1'b1, 1, enc(3, 3, 3));
    bStep(1'b1, 1'b0, 1'b1, 2, enc(1, 0, 0));
    bStep(1'b1, 1'b0, 1'b1, 3, enc(1, 1, 0));
    bStep(1'b1, 1'b0, 1'b1, 4, enc(7, 0, 0));
    bStep(1'b1, 1'b1, 1'b0, 0, 9'd0);
    bc = 0;
    while (!bHalted && bc < 100) begin
      bc++;
      bStep(1'b1, 1'b0, 1'b0, 0, 9'd0);
    end
    check("oob_halted_lit", bHalted, 1);
    check("oob_retired_lit", bRetired, 4);
    check("oob_pc_lit", bProgramCount, 4);
    bRegSel = 2'd3; #1;
    check("oob_r3_lit", bRegRdata, 0);
    bRegSel = 2'd0; #1;
    check("oob_r0_lit", bRegRdata, 0);
    bRegSel = 2'd1; #1;
    check("oob_r1_lit", bRegRdata, 1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/param_paper_processor.md
# param_paper_processor

Parametrised multi-register paper-computer core, the successor to the fixed 2-bit/3-bit paper processor. It adds configurable register count, data width and program depth, plus a writable program store, a richer instruction set (INC, DEC, CLR, JZ, JNZ, JMP, HALT), an explicit start/halt handshake and a retired-instruction counter. It sits at the top of the paper-processor design and is driven by the board clock enable and a host/test loader.

## Interface
Parameters:
- DATA_W, 8, width of each general register
- NUM_REGS, 4, number of general registers (2..16)
- PC_W, 4, program counter width; program depth = 2^PC_W
- Derived (localparam): RI_W = clog2(NUM_REGS) (min 1); INSTR_W = 3 + RI_W + PC_W, fields {op[2:0], ridx[RI_W-1:0], tgt[PC_W-1:0]} MSB first

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state except program store
- clk_en  in  1  execution enable; state machine advances only when 1
- start  in  1  begin execution from address 0 (sampled in IDLE with clk_en=1)
- prog_we  in  1  program store write strobe (honoured only in IDLE)
- prog_addr  in  PC_W  program store write address
- prog_wdata  in  INSTR_W  program store write data
- reg_sel  in  RI_W  debug register select
- reg_rdata  out  DATA_W  combinational read of register reg_sel (0 if out of range)
- programCount  out  PC_W  current PC
- stateCount  out  2  FSM state: 00 IDLE, 01 FETCH, 10 EXEC
- instruction  out  INSTR_W  latched instruction register
- running  out  1  1 in FETCH/EXEC
- halted  out  1  sticky: set on HALT, cleared by start or reset
- retired  out  16  instructions completed, saturating at 16'hFFFF

## Operation
- Opcodes: 000 NOP; 001 INC r (r+1, wraps 2^DATA_W-1 -> 0); 010 DEC r (r-1, saturates at 0); 011 JZ r,t (PC<=t if r==0); 100 JMP t; 101 CLR r; 110 JNZ r,t (PC<=t if r!=0); 111 HALT.
- Non-jump and untaken-jump instructions: PC<=PC+1, wrapping 2^PC_W-1 -> 0.
- Register index >= NUM_REGS: reads as 0, writes ignored; JZ on such index always taken, JNZ never.
- FSM (all transitions require clk_en=1):
  - IDLE: start=1 -> FETCH, PC<=0, halted<=0. Registers and retired NOT cleared by start.
  - FETCH: instruction<=mem[PC] -> EXEC.
  - EXEC: perform instruction, retired<=retired+1 (saturating); HALT -> IDLE, halted<=1, PC unchanged; otherwise -> FETCH.
- start outside IDLE ignored.
- Program writes: mem[prog_addr]<=prog_wdata on any clk edge in IDLE, independent of clk_en; ignored in FETCH/EXEC.
- start and prog_we in same IDLE cycle: both honoured; the subsequent FETCH sees the new word.
- clk_en=0: FSM, PC, registers, instruction, retired frozen.
- Reset (any time, including mid-instruction): stateCount=00, programCount=0, instruction=0, all registers=0, running=0, halted=0, retired=0. Program store contents unaffected.

## Timing
- All outputs registered except reg_rdata and running (decoded from state).
- Instruction latency: 2 enabled cycles (FETCH, EXEC). Start accepted at enabled edge N -> FETCH after N, register/PC update at edge N+2.
- Register write visible on reg_rdata immediately after the EXEC edge.
- halted rises at the EXEC edge of HALT, same edge running falls.
- Jump taken: next FETCH reads mem[t], no bubble.

## Test plan
- Reset then load {INC r1, INC r1, HALT} at 0..2, DATA_W=8, NUM_REGS=4, pulse start with clk_en=1 -> after 6 enabled cycles halted=1, programCount=2, r1=2, retired=3.
- Loop: r0 preset to 3 by three INCs, then addr3 DEC r0, addr4 JNZ r0,3, addr5 HALT -> r0=0, retired=3+6+1=10, halted=1, PC=5.
- Boundaries: 255 INCs then INC on r2 -> r2 wraps to 0; DEC on r3=0 -> stays 0; JMP to 15 holding NOP -> PC wraps to 0.
- clk_en toggled 0/1 every cycle during a program -> identical final registers/retired, twice the clk cycles; prog_we while running -> memory unchanged (verified by rerun).
- Assert reset during EXEC of INC r1 with r1=5 -> immediately all outputs 0, r1=0; program retained, restart reproduces result.
- Out-of-range index (NUM_REGS=3, ridx=3): INC ignored, reg_rdata=0, JZ r3 taken.
